// File: rtl/dims_rtx.sv
// Real-time shaded-sphere renderer: VGA raster timing plus per-pixel Lambert-like
// shading of a sphere under a latched, programmable light position.
module dims_rtx #(
  parameter int VGA_COLOR_DEPTH = 4,
  parameter int LOC_WIDTH       = 16,
  parameter int X_WIDTH         = 640,
  parameter int X_FRONT_PORCH   = 16,
  parameter int X_SYNC          = 96,
  parameter int X_BACK_PORCH    = 48,
  parameter int Y_WIDTH         = 480,
  parameter int Y_FRONT_PORCH   = 10,
  parameter int Y_SYNC          = 2,
  parameter int Y_BACK_PORCH    = 33,
  parameter int R_LOG2          = 7
) (
  input  logic                              GCLK,
  input  logic                              BTNC,
  input  logic signed [LOC_WIDTH-1:0]       L_LOC_X,
  input  logic signed [LOC_WIDTH-1:0]       L_LOC_Y,
  input  logic signed [LOC_WIDTH-1:0]       L_LOC_Z,
  input  logic                              L_LOC_vld,
  output logic        [VGA_COLOR_DEPTH-1:0] VGA_R,
  output logic        [VGA_COLOR_DEPTH-1:0] VGA_G,
  output logic        [VGA_COLOR_DEPTH-1:0] VGA_B,
  output logic                              VGA_HS,
  output logic                              VGA_VS
);

  localparam int H_TOTAL      = X_WIDTH + X_FRONT_PORCH + X_SYNC + X_BACK_PORCH;
  localparam int V_TOTAL      = Y_WIDTH + Y_FRONT_PORCH + Y_SYNC + Y_BACK_PORCH;
  localparam int HW           = $clog2(H_TOTAL);
  localparam int VW           = $clog2(V_TOTAL);
  localparam int H_SYNC_START = X_WIDTH + X_FRONT_PORCH;
  localparam int H_SYNC_END   = H_SYNC_START + X_SYNC;
  localparam int V_SYNC_START = Y_WIDTH + Y_FRONT_PORCH;
  localparam int V_SYNC_END   = V_SYNC_START + Y_SYNC;
  localparam int CMAX         = (2 ** VGA_COLOR_DEPTH) - 1;
  localparam int SHIFT        = 12 + R_LOG2;
  localparam int AW           = 48;
  localparam logic signed [AW-1:0] R2 = AW'(1) <<< (2 * R_LOG2);

  logic                        phase;
  logic [HW-1:0]               h, h_nxt;
  logic [VW-1:0]               v, v_nxt;
  logic                        l_vld;
  logic signed [LOC_WIDTH-1:0] loc_x, loc_y, loc_z;

  logic signed [AW-1:0]        dx, dy, r2, lx, ly, lz, s, lum;
  logic [VGA_COLOR_DEPTH-1:0]  shade;
  logic                        hs_nxt, vs_nxt;

  // Lookahead raster position: the pixel that becomes current at the next enable.
  always_comb begin
    h_nxt = h + HW'(1);
    v_nxt = v;
    if (h == HW'(H_TOTAL - 1)) begin
      h_nxt = '0;
      v_nxt = (v == VW'(V_TOTAL - 1)) ? '0 : v + VW'(1);
    end
    hs_nxt = (h_nxt >= HW'(H_SYNC_START)) && (h_nxt < HW'(H_SYNC_END));
    vs_nxt = (v_nxt >= VW'(V_SYNC_START)) && (v_nxt < VW'(V_SYNC_END));
  end

  // Shade the lookahead pixel so the registered colour lines up with h,v.
  always_comb begin
    dx  = AW'($signed({1'b0, h_nxt})) - AW'(X_WIDTH / 2);
    dy  = AW'(Y_WIDTH / 2) - AW'($signed({1'b0, v_nxt}));
    r2  = dx * dx + dy * dy;
    lx  = AW'(loc_x);
    ly  = AW'(loc_y);
    lz  = AW'(loc_z);
    s   = dx * lx + dy * ly + (lz <<< R_LOG2);
    lum = (s * AW'(CMAX)) >>> SHIFT;
    shade = '0;
    if ((h_nxt < HW'(X_WIDTH)) && (v_nxt < VW'(Y_WIDTH)) && (r2 < R2)) begin
      if (!l_vld)
        shade = VGA_COLOR_DEPTH'(4);
      else if (lum[AW-1])
        shade = '0;
      else if (lum > AW'(CMAX))
        shade = '1;
      else
        shade = lum[VGA_COLOR_DEPTH-1:0];
    end
  end

  always_ff @(posedge GCLK) begin
    if (BTNC) begin
      phase  <= 1'b0;
      h      <= '0;
      v      <= '0;
      l_vld  <= 1'b0;
      loc_x  <= '0;
      loc_y  <= '0;
      loc_z  <= '0;
      VGA_R  <= '0;
      VGA_G  <= '0;
      VGA_B  <= '0;
      VGA_HS <= 1'b0;
      VGA_VS <= 1'b0;
    end else begin
      phase <= ~phase;
      if (L_LOC_vld) begin
        loc_x <= L_LOC_X;
        loc_y <= L_LOC_Y;
        loc_z <= L_LOC_Z;
        l_vld <= 1'b1;
      end
      if (phase) begin
        h      <= h_nxt;
        v      <= v_nxt;
        VGA_R  <= shade;
        VGA_G  <= shade;
        VGA_B  <= shade;
        VGA_HS <= hs_nxt;
        VGA_VS <= vs_nxt;
      end
    end
  end

endmodule

// File: tb/tb_dims_rtx.sv
// Bench for dims_rtx: a reduced-geometry instance for shading/frame checks and a
// default-geometry instance for line timing, both against a pixel-level model.
module tb_dims_rtx;

  localparam int SXW = 64, SXF = 4, SXS = 8, SXB = 4;
  localparam int SYW = 48, SYF = 2, SYS = 2, SYB = 3, SRL = 4;
  localparam int SHT = SXW + SXF + SXS + SXB;
  localparam int SFRAME = SHT * (SYW + SYF + SYS + SYB);

  logic               GCLK = 1'b0;
  logic               BTNC = 1'b1;
  logic signed [15:0] l_x = '0, l_y = '0, l_z = '0;
  logic               l_vld = 1'b0;
  logic [3:0]         s_r, s_g, s_b, f_r, f_g, f_b;
  logic               s_hs, s_vs, f_hs, f_vs;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  // Light history seen by the model: current and previous latched values.
  bit     cur_v, prv_v;
  longint cur_x, cur_y, cur_z, prv_x, prv_y, prv_z;
  int     eff_cyc;

  dims_rtx #(
    .X_WIDTH(SXW), .X_FRONT_PORCH(SXF), .X_SYNC(SXS), .X_BACK_PORCH(SXB),
    .Y_WIDTH(SYW), .Y_FRONT_PORCH(SYF), .Y_SYNC(SYS), .Y_BACK_PORCH(SYB),
    .R_LOG2(SRL)
  ) u_dut (
    .GCLK(GCLK), .BTNC(BTNC),
    .L_LOC_X(l_x), .L_LOC_Y(l_y), .L_LOC_Z(l_z), .L_LOC_vld(l_vld),
    .VGA_R(s_r), .VGA_G(s_g), .VGA_B(s_b), .VGA_HS(s_hs), .VGA_VS(s_vs)
  );

  dims_rtx u_full (
    .GCLK(GCLK), .BTNC(BTNC),
    .L_LOC_X(l_x), .L_LOC_Y(l_y), .L_LOC_Z(l_z), .L_LOC_vld(l_vld),
    .VGA_R(f_r), .VGA_G(f_g), .VGA_B(f_b), .VGA_HS(f_hs), .VGA_VS(f_vs)
  );

  always #5 GCLK = ~GCLK;

  always @(posedge GCLK) begin
    if (BTNC) cyc <= 0;
    else      cyc <= cyc + 1;
  end

  initial begin
    #(10 * 200000);
    $display("FAIL watchdog: time limit reached, tests=%0d failed=%0d", tests, fails);
    $fatal(1, "watchdog");
  end

  // Colour/sync of raster pixel index p, from the raster and shading rules directly.
  function automatic void model(input int xw, xf, xs, xb, yw, yf, ys, yb, rl, p,
                                input bit lit, input longint mx, my, mz,
                                output int col, output bit hs, output bit vs);
    int ht = xw + xf + xs + xb;
    int vt = yw + yf + ys + yb;
    int hh, vv;
    longint dx, dy, s, t;
    hh  = p % ht;
    vv  = (p / ht) % vt;
    hs  = (hh >= xw + xf) && (hh < xw + xf + xs);
    vs  = (vv >= yw + yf) && (vv < yw + yf + ys);
    col = 0;
    if (hh < xw && vv < yw) begin
      dx = hh - xw / 2;
      dy = yw / 2 - vv;
      if (dx * dx + dy * dy < (64'sd1 << (2 * rl))) begin
        if (!lit) col = 4;
        else begin
          s = dx * mx + dy * my + mz * (64'sd1 << rl);
          t = s * 15;
          if (t < 0) col = 0;
          else begin
            t   = t / (64'sd1 << (12 + rl));
            col = (t > 15) ? 15 : int'(t);
          end
        end
      end
    end
  endfunction

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_model();
    int p, col;
    bit hs, vs, lit;
    longint mx, my, mz;
    p = cyc >> 1;
    if (2 * p - 1 >= eff_cyc) begin lit = cur_v; mx = cur_x; my = cur_y; mz = cur_z; end
    else                      begin lit = prv_v; mx = prv_x; my = prv_y; mz = prv_z; end
    model(SXW, SXF, SXS, SXB, SYW, SYF, SYS, SYB, SRL, p, lit, mx, my, mz, col, hs, vs);
    check("rand small R", int'(s_r), col);
    check("rand small G", int'(s_g), col);
    check("rand small B", int'(s_b), col);
    check("rand small HS", int'(s_hs), int'(hs));
    check("rand small VS", int'(s_vs), int'(vs));
    model(640, 16, 96, 48, 480, 10, 2, 33, 7, p, lit, mx, my, mz, col, hs, vs);
    check("rand full R", int'(f_r), col);
    check("rand full HS", int'(f_hs), int'(hs));
    check("rand full VS", int'(f_vs), int'(vs));
  endtask

  task automatic do_reset();
    BTNC = 1'b1;
    @(posedge GCLK);
    #1;
    BTNC  = 1'b0;
    cur_v = 0; prv_v = 0;
    cur_x = 0; cur_y = 0; cur_z = 0;
    prv_x = 0; prv_y = 0; prv_z = 0;
    eff_cyc = 0;
  endtask

  task automatic pulse(input int x, input int y, input int z);
    l_x = 16'(x); l_y = 16'(y); l_z = 16'(z);
    l_vld = 1'b1;
    @(posedge GCLK);
    #1;
    l_vld = 1'b0;
    prv_v = cur_v; prv_x = cur_x; prv_y = cur_y; prv_z = cur_z;
    cur_v = 1; cur_x = x; cur_y = y; cur_z = z;
    eff_cyc = cyc;
    l_x = 16'($urandom); l_y = 16'($urandom); l_z = 16'($urandom);
  endtask

  task automatic goto_abs(input int p);
    int n;
    n = 2 * p - cyc;
    if (n < 1) n = 1;
    repeat (n) @(posedge GCLK);
    @(negedge GCLK);
  endtask

  task automatic goto_px(input int hh, input int vv);
    int t, p;
    t = vv * SHT + hh;
    p = (cyc >> 1) + 1;
    p = p + ((t - (p % SFRAME)) + SFRAME) % SFRAME;
    goto_abs(p);
  endtask

  typedef struct {
    int h;
    int v;
    bit lit;
    int x;
    int y;
    int z;
    int exp_i;
  } vec_t;

  initial begin
    vec_t vecs[13];
    vecs[0]  = '{32, 24, 1'b0, 0, 0, 0, 4};
    vecs[1]  = '{47, 24, 1'b0, 0, 0, 0, 4};
    vecs[2]  = '{48, 24, 1'b0, 0, 0, 0, 0};
    vecs[3]  = '{0,  0,  1'b0, 0, 0, 0, 0};
    vecs[4]  = '{32, 5,  1'b1, 4096, 0, 0, 0};
    vecs[5]  = '{32, 9,  1'b1, 0, 4096, 0, 14};
    vecs[6]  = '{36, 20, 1'b1, 4096, 4096, 0, 7};
    vecs[7]  = '{32, 23, 1'b1, 0, 0, 2048, 7};
    vecs[8]  = '{17, 24, 1'b1, 4096, 0, 0, 0};
    vecs[9]  = '{30, 24, 1'b1, 0, 0, -4096, 0};
    vecs[10] = '{32, 24, 1'b1, 5160, 5160, 5160, 15};
    vecs[11] = '{40, 24, 1'b1, 4096, 0, 0, 7};
    vecs[12] = '{70, 24, 1'b1, 0, 0, 4096, 0};

    repeat (3) @(posedge GCLK);
    do_reset();
    @(negedge GCLK);
    check("reset R", int'(s_r), 0);
    check("reset HS", int'(s_hs), 0);
    check("reset VS", int'(s_vs), 0);
    check("reset full HS", int'(f_hs), 0);

    // Line timing on the full-size raster.
    goto_abs(655);  check("hs before rise", int'(f_hs), 0);
    goto_abs(656);  check("hs rise", int'(f_hs), 1);
    goto_abs(751);  check("hs last", int'(f_hs), 1);
    goto_abs(752);  check("hs fall", int'(f_hs), 0);
    goto_abs(800 + 655); check("line1 hs before rise", int'(f_hs), 0);
    goto_abs(800 + 656); check("line1 hs rise", int'(f_hs), 1);

    do_reset();
    for (int i = 0; i < 13; i++) begin
      if (vecs[i].lit) pulse(vecs[i].x, vecs[i].y, vecs[i].z);
      goto_px(vecs[i].h, vecs[i].v);
      check($sformatf("vec%0d R", i), int'(s_r), vecs[i].exp_i);
      check($sformatf("vec%0d G", i), int'(s_g), vecs[i].exp_i);
      check($sformatf("vec%0d B", i), int'(s_b), vecs[i].exp_i);
    end

    // One-cycle light pulses; later garbage on the inputs must be ignored.
    pulse(0, 0, -4096);
    pulse(4096, 0, 0);
    l_x = -16'sd8192; l_y = 16'sd777; l_z = -16'sd3000;
    goto_px(36, 20); check("persist (36,20)", int'(s_r), 3);
    goto_px(40, 24); check("persist (40,24)", int'(s_r), 7);

    goto_px(0, 49);  check("vs line 49", int'(s_vs), 0);
    goto_px(0, 50);  check("vs line 50", int'(s_vs), 1);
    goto_px(79, 51); check("vs line 51 end", int'(s_vs), 1);
    goto_px(0, 52);  check("vs line 52", int'(s_vs), 0);

    // Reset mid-line while a lit sphere pixel is on the outputs.
    pulse(0, 0, 4096);
    goto_px(32, 24); check("pre-reset centre", int'(s_r), 15);
    do_reset();
    @(negedge GCLK);
    check("midreset R", int'(s_r), 0);
    check("midreset G", int'(s_g), 0);
    check("midreset B", int'(s_b), 0);
    goto_px(32, 24); check("post-reset ambient", int'(s_r), 4);

    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 9) == 0)
        pulse(int'($urandom_range(0, 16383)) - 8192,
              int'($urandom_range(0, 16383)) - 8192,
              int'($urandom_range(0, 16383)) - 8192);
      else begin
        l_x = 16'($urandom); l_y = 16'($urandom); l_z = 16'($urandom);
      end
      repeat ($urandom_range(1, 40)) @(posedge GCLK);
      @(negedge GCLK);
      check_model();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
